// File: rtl/neopixel_driver.sv
// neopixel_driver: bus-mapped pixel file serialized onto a WS2812-style one-wire output.
// Optional run/stop control register at C_PIXELS+1 when NEOPIXEL_CTRL_REG_EN is defined.
module neopixel_driver #(
  parameter int C_RATE = 125000000,
  parameter int C_PIXELS = 12,
  parameter int C_T0H_NS = 400,
  parameter int C_T1H_NS = 800,
  parameter int C_TBIT_NS = 1250,
  parameter int C_TRESET_NS = 60000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_readf,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        dout
);
  localparam int MHZ = C_RATE / 1000000;
  localparam int T0H_C = MHZ * C_T0H_NS / 1000;
  localparam int T1H_C = MHZ * C_T1H_NS / 1000;
  localparam int TBIT_C = MHZ * C_TBIT_NS / 1000;
  localparam int TRESET_C = MHZ * C_TRESET_NS / 1000;
  localparam int CW = $clog2((TRESET_C > TBIT_C ? TRESET_C : TBIT_C) + 1);
  localparam int PW = C_PIXELS > 1 ? $clog2(C_PIXELS) : 1;
  localparam logic [CW-1:0] T0H = CW'(T0H_C);
  localparam logic [CW-1:0] T1H = CW'(T1H_C);
  localparam logic [CW-1:0] LAST_BIT = CW'(TBIT_C - 1);
  localparam logic [CW-1:0] LAST_LATCH = CW'(TRESET_C - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(C_PIXELS - 1);
  localparam logic [31:0] FC_ADDR = 32'(C_PIXELS);
  typedef enum logic [1:0] {
    S_LATCH,
    S_BIT
`ifdef NEOPIXEL_CTRL_REG_EN
    , S_IDLE
`endif
  } state_t;
  state_t state, state_n;
  logic [23:0] mem [C_PIXELS];
  logic [CW-1:0] cnt, cnt_n;
  logic [23:0] shift, shift_n;
  logic [PW-1:0] pixel, pixel_n;
  logic [4:0] bit_idx, bit_n;
  logic load, frame_done, dout_n, hit_pix;
  logic [31:0] frame_count, read_n;
  logic unused_bits;
  assign unused_bits = ^write_data[31:24];
  assign hit_pix = address < 32'(C_PIXELS);
`ifdef NEOPIXEL_CTRL_REG_EN
  localparam logic [31:0] CTRL_ADDR = 32'(C_PIXELS + 1);
  logic run;
  always_ff @(posedge clock)
    if (reset) run <= 1'b1;
    else if (write_readf && address == CTRL_ADDR) run <= write_data[0];
  assign read_n = hit_pix ? {8'h0, mem[address[PW-1:0]]} : address == FC_ADDR ? frame_count :
                  address == CTRL_ADDR ? {31'h0, run} : 32'h0;
`else
  assign read_n = hit_pix ? {8'h0, mem[address[PW-1:0]]} : address == FC_ADDR ? frame_count : 32'h0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    shift_n = shift;
    pixel_n = pixel;
    bit_n = bit_idx;
    load = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_LATCH: if (cnt == LAST_LATCH) begin
        cnt_n = '0;
`ifdef NEOPIXEL_CTRL_REG_EN
        state_n = run ? S_BIT : S_IDLE;
        load = run;
`else
        state_n = S_BIT;
        load = 1'b1;
`endif
      end
      S_BIT: if (cnt == LAST_BIT) begin
        cnt_n = '0;
        if (bit_idx != 5'd0) begin
          shift_n = shift << 1;
          bit_n = bit_idx - 5'd1;
        end else if (pixel != LAST_PIX) begin
          shift_n = mem[pixel + 1'b1];
          pixel_n = pixel + 1'b1;
          bit_n = 5'd23;
        end else begin
          state_n = S_LATCH;
          frame_done = 1'b1;
        end
      end
`ifdef NEOPIXEL_CTRL_REG_EN
      S_IDLE: begin
        cnt_n = '0;
        state_n = run ? S_BIT : S_IDLE;
        load = run;
      end
`endif
      default: begin
        state_n = S_LATCH;
        cnt_n = '0;
      end
    endcase
    // each pixel word is snapshotted as its first bit starts
    if (load) begin
      shift_n = mem[0];
      pixel_n = '0;
      bit_n = 5'd23;
    end
    dout_n = state_n == S_BIT && cnt_n < (shift_n[23] ? T1H : T0H);
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_LATCH;
      cnt <= '0;
      shift <= '0;
      pixel <= '0;
      bit_idx <= '0;
      dout <= 1'b0;
      frame_count <= '0;
      read_data <= '0;
      for (int i = 0; i < C_PIXELS; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      pixel <= pixel_n;
      bit_idx <= bit_n;
      dout <= dout_n;
      frame_count <= frame_count + {31'h0, frame_done};
      read_data <= read_n;
      if (write_readf && hit_pix) mem[address[PW-1:0]] <= write_data[23:0];
    end
endmodule

// File: tb/tb_neopixel_driver.sv
// tb_neopixel_driver: scoreboard bench; pulses decoded from dout are compared with expected bit timings.
module tb_neopixel_driver;
  localparam int NPIX = 3;
  localparam int T0H = 10;
  localparam int T1H = 20;
  localparam int TBIT = 31;
  localparam int TRESET = 100;
  typedef struct packed {logic [15:0] hi; logic [15:0] lo;} pulse_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic write_readf = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic dout;
  pulse_t obs_q[$];
  pulse_t exp_q[$];
  logic prev = 1'b0, seen = 1'b0, flush = 1'b0;
  logic [15:0] hi = '0, lo = '0;
  int checks = 0, errors = 0;

  neopixel_driver #(.C_RATE(25000000), .C_PIXELS(NPIX), .C_T0H_NS(400), .C_T1H_NS(800),
                    .C_TBIT_NS(1250), .C_TRESET_NS(4000)) dut (
    .clock(clock), .reset(reset), .write_readf(write_readf), .address(address),
    .write_data(write_data), .read_data(read_data), .dout(dout));

  always #5 clock = ~clock;

  // a pulse is recorded at the rising edge that follows it: {high cycles, low cycles}
  always @(negedge clock) begin
    prev <= dout;
    if (flush) seen <= 1'b0;
    else if (dout && !prev) begin
      if (seen) obs_q.push_back({hi, lo});
      hi <= 16'd1;
      lo <= 16'd0;
      seen <= 1'b1;
    end else if (dout) hi <= hi + 16'd1;
    else lo <= lo + 16'd1;
  end

  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
    logic [23:0] px [NPIX];
    logic [15:0] h;
    px[0] = p0; px[1] = p1; px[2] = p2;
    for (int p = 0; p < NPIX; p++)
      for (int b = 23; b >= 0; b--) begin
        h = px[p][b] ? 16'(T1H) : 16'(T0H);
        exp_q.push_back({h, 16'(TBIT) - h + ((p == NPIX - 1 && b == 0) ? 16'(TRESET) : 16'd0)});
      end
  endtask

  task automatic get_pulse(output pulse_t p, output bit ok);
    int t = 0;
    while (obs_q.size() == 0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    ok = obs_q.size() != 0;
    p = '0;
    if (ok) p = obs_q.pop_front();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    write_readf = 1'b1; address = a; write_data = d;
    @(negedge clock);
    write_readf = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    address = a;
    @(negedge clock);
    v = read_data;
  endtask

  task automatic test_reset;
    int n = 0;
    flush = 1'b1; reset = 1'b1; address = 32'd3;
    repeat (3) @(negedge clock);
    reset = 1'b0; flush = 1'b0;
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", dout); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", read_data); end
    while (dout !== 1'b1 && n < 1000) begin
      if (n == 0) begin write_readf = 1'b1; address = 32'd0; write_data = 32'h00800001; end
      else write_readf = 1'b0;
      n++;
      @(negedge clock);
    end
    checks++; if (n != TRESET) begin errors++; $display("FAIL reset_latch_low got %0d want %0d", n, TRESET); end
  endtask

  task automatic test_bus;
    logic [31:0] v;
    wr(32'd1, 32'hFF123456);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL same_cycle_read got %h want 0", read_data); end
    @(negedge clock);
    checks++; if (read_data !== 32'h00123456) begin errors++; $display("FAIL read_after_write got %h want 00123456", read_data); end
    wr(32'h80000001, 32'hFFFFFFFF);
    wr(32'd20, 32'hFFFFFFFF);
    rd(32'd20, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_unmapped got %h want 0", v); end
    rd(32'h80000001, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_alias got %h want 0", v); end
    rd(32'd1, v);
    checks++; if (v !== 32'h00123456) begin errors++; $display("FAIL alias_write_ignored got %h want 00123456", v); end
    wr(32'd3, 32'hFFFFFFFF);
    rd(32'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL frame_count_ro got %h want 0", v); end
`ifdef NEOPIXEL_CTRL_REG_EN
    rd(32'd4, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ctrl_reset got %h want 1", v); end
`else
    wr(32'd4, 32'h0);
    rd(32'd4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_absent got %h want 0", v); end
`endif
    push_frame(24'h800001, 24'h123456, 24'h000000);
  endtask

  task automatic test_frame;
    pulse_t o, e;
    bit ok;
    logic [31:0] v;
    for (int i = 0; i < 24 * NPIX; i++) begin
      get_pulse(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL frame1_pulse%0d got hi %0d lo %0d want hi %0d lo %0d", i, o.hi, o.lo, e.hi, e.lo);
        if (!ok) break;
      end
    end
    rd(32'd3, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL frame_count_1 got %0d want 1", v); end
  endtask

  task automatic test_snapshot;
    pulse_t o, e;
    bit ok;
    logic [31:0] v;
    repeat (24 * TBIT + 60) @(negedge clock);
    wr(32'd0, 32'h00000003);
    wr(32'd1, 32'h000F0F0F);
    wr(32'd2, 32'h00A5A5A5);
    push_frame(24'h800001, 24'h123456, 24'hA5A5A5);
    push_frame(24'h000003, 24'h0F0F0F, 24'hA5A5A5);
    for (int i = 0; i < 48 * NPIX; i++) begin
      get_pulse(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL snapshot_pulse%0d got hi %0d lo %0d want hi %0d lo %0d", i, o.hi, o.lo, e.hi, e.lo);
        if (!ok) break;
      end
      if (i == 24 * NPIX - 1) begin
        rd(32'd3, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL frame_count_2 got %0d want 2", v); end
      end
    end
    rd(32'd3, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL frame_count_3 got %0d want 3", v); end
  endtask

  task automatic test_reset_mid;
    pulse_t o, e;
    bit ok;
    int n = 0;
    repeat (22 * TBIT + 6) @(negedge clock);
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL in_one_bit got %b want 1", dout); end
    reset = 1'b1; flush = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL mid_reset_dout got %b want 0", dout); end
    while (dout !== 1'b1 && n < 1000) begin
      if (n == 0) begin obs_q.delete(); exp_q.delete(); address = 32'd3; end
      if (n == 1) begin
        flush = 1'b0;
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL mid_reset_frame_count got %h want 0", read_data); end
      end
      n++;
      @(negedge clock);
    end
    checks++; if (n != TRESET) begin errors++; $display("FAIL mid_reset_latch_low got %0d want %0d", n, TRESET); end
    push_frame(24'h0, 24'h0, 24'h0);
    for (int i = 0; i < 24 * NPIX; i++) begin
      get_pulse(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL zero_pulse%0d got hi %0d lo %0d want hi %0d lo %0d", i, o.hi, o.lo, e.hi, e.lo);
        if (!ok) break;
      end
    end
  endtask

`ifdef NEOPIXEL_CTRL_REG_EN
  task automatic test_ctrl;
    logic [31:0] v;
    int n = 0, t = 0, highs = 0;
    repeat (100) @(negedge clock);
    wr(32'd4, 32'h0);
    rd(32'd4, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_cleared got %h want 0", v); end
    while (n < 200 && t < 4000) begin
      @(negedge clock);
      t++;
      n = dout ? 0 : n + 1;
    end
    checks++; if (n < 200) begin errors++; $display("FAIL reach_idle got %0d want 200", n); end
    rd(32'd3, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL idle_frame_count got %0d want 2", v); end
    repeat (500) begin
      @(negedge clock);
      if (dout) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL idle_low got %0d want 0", highs); end
    rd(32'd3, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL frozen_frame_count got %0d want 2", v); end
    flush = 1'b1;
    obs_q.delete();
    wr(32'd0, 32'h00800000);
    flush = 1'b0;
    wr(32'd4, 32'h1);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL restart_wait got %b want 0", dout); end
    @(negedge clock);
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL restart_next_cycle got %b want 1", dout); end
    n = 0;
    while (dout === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    checks++; if (n != T1H) begin errors++; $display("FAIL restart_first_bit got %0d want %0d", n, T1H); end
    rd(32'd4, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ctrl_set got %h want 1", v); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_bus;
    test_frame;
    test_snapshot;
    test_reset_mid;
`ifdef NEOPIXEL_CTRL_REG_EN
    test_ctrl;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neopixel_driver.md
Name: neopixel_driver

Overview:
- Downstream consumer of the neopixel control interface.
- Holds a C_PIXELS-deep pixel register file, written and read over the write_readf/address/write_data/read_data bus.
- Continuously serializes the pixel file onto a single WS2812-style one-wire output, with one reset/latch low period between frames.
- Reports a completed-frame counter through the same bus.

Parameters:
- C_RATE, 125000000, clock frequency in Hz; must be a multiple of 1000000.
- C_PIXELS, 12, number of pixels in the chain (1..1024).
- C_T0H_NS, 400, high time of a 0 bit in ns.
- C_T1H_NS, 800, high time of a 1 bit in ns.
- C_TBIT_NS, 1250, total bit period in ns.
- C_TRESET_NS, 60000, low latch period between frames in ns.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write_readf  in  1  1 = write write_data to address this cycle.
- address  in  32  register address; full 32 bits decoded.
- write_data  in  32  write data; bits [23:0] = {G,R,B}, bits [31:24] ignored.
- read_data  out  32  registered read data.
- dout  out  1  serial pixel stream to the LED chain.

Behaviour:
- Cycle counts = (C_RATE/1000000)*NS/1000, integer truncation. Defaults: T0H=50, T1H=100, TBIT=156, TRESET=7500.
- Address map:
  - 0..C_PIXELS-1: pixel words, 24 bits each, read/write.
  - C_PIXELS: frame_count, read-only, 32 bits, wraps at 2^32.
  - C_PIXELS+1: control register (optional feature).
  - All other addresses: writes ignored, reads return 0.
- Write: when write_readf=1 and address is a pixel index, mem[address] <= write_data[23:0] at that clock edge.
- Read: every cycle, read_data <= {8'h0, mem[address]} (or frame_count / ctrl / 0), independent of write_readf. Latency 1.
  - Same-cycle write and read of the same address returns the old value.
- Reset: mem cleared to 0, frame_count=0, read_data=0, dout=0, state=S_LATCH with counter cleared.
  - Reset asserted mid-frame: dout=0 on the next edge, then the full TRESET low period before pixel 0.
- States:
  - S_LATCH: dout=0 for TRESET cycles. Then shift <= mem[0], pixel=0, bit=23, go to S_BIT.
  - S_BIT: cycle counter 0..TBIT-1; dout=1 while counter < (shift[23] ? T1H : T0H), else 0. At counter=TBIT-1:
    - If bit>0: shift left, bit decrements.
    - Else if pixel<C_PIXELS-1: shift <= mem[pixel+1], pixel increments, bit=23. No gap cycle between pixels.
    - Else: frame_count increments, go to S_LATCH.
- Frame period (defaults) = 12*24*156 + 7500 = 52428 cycles; bits are contiguous.
- Pixel word is snapshotted when its first bit starts:
  - A write to the pixel currently shifting, or to an earlier one, takes effect next frame.
  - A write to a later pixel takes effect this frame.
- MSB (bit 23, G[7]) transmitted first.

Optional Feature:
- Macro NEOPIXEL_CTRL_REG_EN.
- Defined:
  - Control register at C_PIXELS+1; bit0 = run, reset value 1; reads return {31'h0, run}.
  - run cleared mid-frame: the current frame and its S_LATCH complete, then dout holds 0 in S_IDLE.
  - run set while in S_IDLE: engine enters S_BIT with pixel 0 on the next cycle. No extra latch period, since the idle time already exceeds TRESET.
  - frame_count increments only for completed frames.
- Not defined: no S_IDLE state; engine always runs; address C_PIXELS+1 reads 0 and writes are ignored.

Test Plan:
- Release reset with mem zero -> dout low 7500 cycles, then 288 bits each 50 high / 106 low, then 7500 low.
- Write addr 0 = 0x00800001 during the first S_LATCH -> first pixel: bit23 high 100, bits 22..1 high 50, bit0 high 100.
- Write addr 5 = 0xFF123456, then read addr 5 -> read_data = 0x00123456 one cycle after the address is presented. Write addr 20 = 0xFFFFFFFF -> no change anywhere; read addr 20 returns 0.
- Run 2 full frames after reset -> read addr 12 returns 0x00000002. Write addr 3 while pixel 3 is shifting -> pixel 3 emits the old value this frame and the new value next frame.
- Assert reset 1 cycle in the middle of a 1-bit high phase -> dout=0 next cycle, frame_count=0, 7500 low cycles, then a frame of all-zero bits.
- With NEOPIXEL_CTRL_REG_EN: write addr 13 = 0 mid-frame -> frame finishes, latch completes, dout stays 0 for 100000 cycles, frame_count frozen. Write 1 -> first bit of pixel 0 starts on the next cycle.
